// File: rtl/spi_pkg.sv
// Shared definitions for the SPI controller slice.
// Holds the frame geometry, the R/W bit encodings, the controller FSM state type and a
// helper that packs a host request into the 16-bit frame shifted out on COPI.
package spi_pkg;

  localparam int unsigned FrameWidth = 16;
  localparam int unsigned AddrWidth  = 7;
  localparam int unsigned DataWidth  = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } spi_state_e;

  // Frame layout, MSB first on the wire: {rw, addr[6:0], data[7:0]}.
  function automatic logic [FrameWidth-1:0] build_frame(input logic                 rw,
                                                        input logic [AddrWidth-1:0] addr,
                                                        input logic [DataWidth-1:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Host-side handshake bundle of the SPI controller.
//   req/ready      : frame request, accepted on a cycle with both high
//   rw/addr/wdata  : frame contents, captured at acceptance
//   rdata          : byte shifted in from CIPO during the last frame
//   done           : one-cycle pulse at end of frame
//   busy           : high from acceptance until nCS returns high
// Modport master is the host issuing frames; modport slave is the controller.
interface spi_controller_if;
  import spi_pkg::*;

  logic                 req;
  logic                 ready;
  logic                 rw;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic [DataWidth-1:0] rdata;
  logic                 done;
  logic                 busy;

  modport master (
    output req, rw, addr, wdata,
    input  ready, rdata, done, busy
  );

  modport slave (
    input  req, rw, addr, wdata,
    output ready, rdata, done, busy
  );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period timer.
// Counts 0..ClkDiv-1 and flags the terminal count; held at zero while clear_i is high so the
// first half-period after a frame start is exactly ClkDiv cycles long.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clear_i    : hold the count at zero
//   tick_o     : high in the last cycle of each half-period
module spi_clk_div #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 8'(ClkDiv - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller issuing one 16-bit frame per accepted host request.
// Frame: setup half-period, 16 SCLK pulses (COPI = {rw, addr, wdata} MSB first), hold
// half-period, then nCS high with a done pulse and a 2-half-period gap before ready returns.
// CIPO is sampled in the last cycle of the high phase of bits 8..15 and the byte is published
// on rdata in the done cycle.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : host handshake (slave modport)
//   SCLK, nCS, COPI, CIPO : SPI bus pins; all outputs come straight from flops
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_controller_if.slave   bus,
  output logic              SCLK,
  output logic              nCS,
  output logic              COPI,
  input  logic              CIPO
);

  spi_state_e state_q, state_d;

  logic [3:0]            bit_q, bit_d;      // index of the bit currently on the wire
  logic                  hi_q, hi_d;        // SCLK phase within the current bit
  logic                  gap_q, gap_d;      // second half-period of the gap
  logic [FrameWidth-1:0] tx_q, tx_d;        // bits still to be driven, left aligned
  logic [DataWidth-1:0]  rx_q, rx_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  sclk_q, sclk_d;
  logic                  copi_q, copi_d;
  logic                  ncs_q, ncs_d;
  logic                  done_q, done_d;
  logic                  init_q;            // keeps ready low until the first edge after reset

  logic                  ready;
  logic                  accept;
  logic                  tick;
  logic [FrameWidth-1:0] frame;

  assign ready  = init_q && (state_q == StIdle);
  assign accept = bus.req && ready;
  assign frame  = build_frame(bus.rw, bus.addr, bus.wdata);

  spi_clk_div #(
    .ClkDiv (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == StIdle),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          copi_d  = frame[FrameWidth-1];
          tx_d    = {frame[FrameWidth-2:0], 1'b0};
          bit_d   = '0;
          rx_d    = '0;
          gap_d   = 1'b0;
        end
      end

      StSetup: begin
        if (tick) begin
          state_d = StShift;
          sclk_d  = 1'b1;
          hi_d    = 1'b1;
        end
      end

      StShift: begin
        if (tick) begin
          if (hi_q) begin
            // End of high phase: sample the data byte, then drop SCLK.
            if (bit_q[3]) begin
              rx_d = {rx_q[DataWidth-2:0], CIPO};
            end
            sclk_d = 1'b0;
            hi_d   = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = StHold;
            end else begin
              copi_d = tx_q[FrameWidth-1];
              tx_d   = {tx_q[FrameWidth-2:0], 1'b0};
            end
          end else begin
            sclk_d = 1'b1;
            hi_d   = 1'b1;
            bit_d  = bit_q + 4'd1;
          end
        end
      end

      StHold: begin
        if (tick) begin
          state_d = StGap;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          rdata_d = rx_q;
          gap_d   = 1'b0;
        end
      end

      StGap: begin
        if (tick) begin
          if (gap_q) begin
            state_d = StIdle;
          end else begin
            gap_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      gap_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
      init_q  <= 1'b1;
    end
  end

  assign SCLK      = sclk_q;
  assign nCS       = ncs_q;
  assign COPI      = copi_q;
  assign bus.ready = ready;
  assign bus.busy  = ~ncs_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a driver issues frames and pushes the expected frame, read byte
// and acceptance cycle into a queue; a monitor decodes the SPI pins and pops/compares on done.
// A behavioural register-file peripheral answers on CIPO; the expected read byte comes from
// a separate array updated in issue order.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int D = 4;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          acc;
    bit          b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic SCLK, nCS, COPI, CIPO;

  spi_controller_if bus ();

  spi_controller #(
    .CLK_DIV (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .SCLK  (SCLK),
    .nCS   (nCS),
    .COPI  (COPI),
    .CIPO  (CIPO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] exp_regs [128];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [15:0] p_sh = '0;
  int          p_cnt = 0;
  logic [6:0]  p_addr = '0;
  logic [7:0]  p_regs [128];

  always @(negedge nCS) begin
    p_cnt = 0;
    p_sh  = '0;
  end
  always @(posedge SCLK) if (!nCS) p_sh = {p_sh[14:0], COPI};
  always @(negedge SCLK) begin
    if (!nCS) begin
      if (p_cnt == 7) p_addr = p_sh[6:0];
      p_cnt++;
    end
  end
  always @(posedge nCS) begin
    if (p_cnt == 16 && p_sh[15] == RW_WRITE) p_regs[p_sh[14:8]] = p_sh[7:0];
  end
  always_comb begin
    CIPO = 1'b0;
    if (!nCS && p_cnt >= 8 && p_cnt < 16) CIPO = p_regs[p_addr][3'(15 - p_cnt)];
  end

  // ---------------- monitor ----------------
  int          mon_rises = 0;
  logic [15:0] mon_frame = '0;
  int          mon_acc = 0;
  int          rise_err = 0;
  int          ncs_rise_cyc = 0;
  int          ready_target = 0;
  bit          wait_ready = 0;
  int          viol = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_ncs = 1'b1;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        wait_ready = 0;
      end else begin
        if (SCLK && nCS) viol++;
        if (bus.busy !== !nCS) viol++;
        if (bus.ready && !nCS) viol++;
        if (prev_ncs && !nCS) begin
          mon_acc   = cyc;
          mon_rises = 0;
          mon_frame = '0;
          rise_err  = 0;
          if (exp_q.size() > 0) begin
            check("accept_cycle", cyc, exp_q[0].acc);
            if (exp_q[0].b2b) check("ncs_gap", cyc - ncs_rise_cyc, 2 * D + 1);
          end
        end
        if (!prev_sclk && SCLK) begin
          if (cyc != mon_acc + (2 * mon_rises + 1) * D) rise_err++;
          mon_frame = {mon_frame[14:0], COPI};
          mon_rises++;
        end
        if (bus.done) begin
          ncs_rise_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            check("frame", int'(mon_frame), int'(e.frame));
            check("rdata", int'(bus.rdata), int'(e.rdata));
            check("sclk_pulses", mon_rises, 16);
            check("rise_timing_errs", rise_err, 0);
            check("done_cycle", cyc - mon_acc, 33 * D);
            check("ncs_at_done", int'(nCS), 1);
            wait_ready   = 1;
            ready_target = mon_acc + 35 * D;
          end
        end
        if (wait_ready && bus.ready) begin
          check("ready_cycle", cyc, ready_target);
          wait_ready = 0;
        end
      end
      prev_sclk = SCLK;
      prev_ncs  = nCS;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic rw_v, input logic [6:0] a, input logic [7:0] d,
                      input bit hold, input bit b2b, input bit abort);
    exp_t e;
    int   t = 0;
    bus.rw    = rw_v;
    bus.addr  = a;
    bus.wdata = d;
    bus.req   = 1'b1;
    while (!bus.ready && t < 200 * D) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within %0d cycles", 200 * D);
      bus.req = 1'b0;
      return;
    end
    if (!abort) begin
      e.frame = {rw_v, a, d};
      e.rdata = exp_regs[a];
      e.acc   = cyc + 1;
      e.b2b   = b2b;
      exp_q.push_back(e);
      if (rw_v == RW_WRITE) exp_regs[a] = d;
    end
    @(negedge clk);
    // Fields change after acceptance and must not affect the frame in flight.
    bus.rw    = 1'($urandom);
    bus.addr  = 7'($urandom);
    bus.wdata = 8'($urandom);
    if (!hold) bus.req = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !bus.ready) && t < 200 * D) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || !bus.ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (mon_rises < n && t < 100 * D) begin
      @(negedge clk);
      t++;
    end
    if (mon_rises < n) begin
      checks++;
      errors++;
      $display("FAIL rises_timeout: got %0d expected %0d", mon_rises, n);
    end
  endtask

  initial begin
    bit hold;
    bit prev_hold;
    bus.req   = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 128; i++) begin
      exp_regs[i] = 8'h00;
      p_regs[i]   = 8'h00;
    end
    exp_regs[1] = 8'h3C;
    p_regs[1]   = 8'h3C;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ncs", int'(nCS), 1);
    check("rst_sclk", int'(SCLK), 0);
    check("rst_copi", int'(COPI), 0);
    check("rst_ready", int'(bus.ready), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_rdata", int'(bus.rdata), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", int'(bus.ready), 0);
    @(posedge clk);
    #1 check("ready_after_edge", int'(bus.ready), 1);
    @(negedge clk);

    // Directed write and read.
    send(RW_WRITE, 7'h04, 8'hA5, 0, 0, 0);
    wait_idle();
    send(RW_READ, 7'h01, 8'h00, 0, 0, 0);
    wait_idle();

    // Three back-to-back frames with req held.
    send(RW_WRITE, 7'h06, 8'h11, 1, 0, 0);
    send(RW_READ,  7'h06, 8'h22, 1, 1, 0);
    send(RW_WRITE, 7'h07, 8'h33, 0, 1, 0);
    wait_idle();

    // Request pulsed mid-frame is dropped.
    send(RW_WRITE, 7'h05, 8'h5A, 0, 0, 0);
    wait_rises(3);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    wait_idle();
    repeat (40 * D) @(negedge clk);
    check("no_extra_frame_busy", int'(bus.busy), 0);
    check("no_extra_frame_ncs", int'(nCS), 1);

    // Reset during bit 7 aborts the frame.
    send(RW_WRITE, 7'h03, 8'hEE, 0, 0, 1);
    wait_rises(8);
    check("sclk_high_before_abort", int'(SCLK), 1);
    rst_n = 1'b0;
    #1;
    check("abort_ncs", int'(nCS), 1);
    check("abort_sclk", int'(SCLK), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_ready", int'(bus.ready), 0);
    check("abort_rdata", int'(bus.rdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_abort", int'(bus.ready), 1);
    @(negedge clk);
    send(RW_WRITE, 7'h02, 8'h01, 0, 0, 0);
    wait_idle();

    // Fill 0x00..0x04 with 0xFF, then read them back.
    for (int a = 0; a < 5; a++) send(RW_WRITE, 7'(a), 8'hFF, 0, 0, 0);
    for (int a = 0; a < 5; a++) send(RW_READ, 7'(a), 8'(a), 0, 0, 0);
    wait_idle();

    // Random traffic over a small address window so reads hit earlier writes.
    prev_hold = 0;
    for (int n = 0; n < 24; n++) begin
      hold = ($urandom_range(0, 3) == 0) && (n != 23);
      send(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom), hold, prev_hold, 0);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      prev_hold = hold;
    end
    wait_idle();
    repeat (4 * D) @(negedge clk);

    for (int a = 0; a < 8; a++) check("peripheral_reg", int'(p_regs[a]), int'(exp_regs[a]));
    check("bus_invariant_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
